// File: rtl/alu_result_stage.sv
// Execute-to-memory stage: 2-entry skid buffer holding the ALU result and control fields, with branch resolution.
// Optional bypass source enabled by defining ALU_RESULT_STAGE_FWD_EN.

package types;
  typedef logic [31:0] bus_type;
  typedef logic [4:0]  reg_addr_type;
endpackage

module alu_result_stage
  import types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  bus_type      alu_s,
  input  logic         alu_zero,
  input  reg_addr_type rd,
  input  logic         reg_write,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         branch,
  input  logic         branch_ne,
  input  bus_type      store_data,
  input  bus_type      branch_target,
  output logic         out_valid,
  input  logic         out_ready,
  output bus_type      out_s,
  output bus_type      out_store_data,
  output bus_type      out_branch_target,
  output reg_addr_type out_rd,
  output logic         out_reg_write,
  output logic         out_mem_read,
  output logic         out_mem_write,
  output logic         out_branch_taken,
  output logic         fwd_valid,
  output reg_addr_type fwd_rd,
  output bus_type      fwd_data
);

  typedef struct packed {
    bus_type      s;
    bus_type      store_data;
    bus_type      branch_target;
    reg_addr_type rd;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         branch_taken;
  } entry_t;

  entry_t head_reg, skid_reg, in_entry;
  logic   head_valid_reg, skid_valid_reg;
  logic   accept, xfer;

  // The zero flag is consumed here; only the branch decision travels on.
  always_comb begin
    in_entry               = '0;
    in_entry.s             = alu_s;
    in_entry.store_data    = store_data;
    in_entry.branch_target = branch_target;
    in_entry.rd            = rd;
    in_entry.reg_write     = reg_write & (rd != 5'd0);
    in_entry.mem_read      = mem_read;
    in_entry.mem_write     = mem_write;
    in_entry.branch_taken  = branch & (alu_zero ^ branch_ne);
  end

  assign in_ready = !skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign xfer     = head_valid_reg & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg       <= '0;
      skid_reg       <= '0;
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!head_valid_reg || xfer) begin
      if (skid_valid_reg) begin
        head_reg       <= skid_reg;
        head_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        head_valid_reg <= accept;
        if (accept) head_reg <= in_entry;
      end
    end else if (accept) begin
      skid_reg       <= in_entry;
      skid_valid_reg <= 1'b1;
    end
  end

  assign out_valid         = head_valid_reg;
  assign out_s             = head_reg.s;
  assign out_store_data    = head_reg.store_data;
  assign out_branch_target = head_reg.branch_target;
  assign out_rd            = head_reg.rd;
  assign out_reg_write     = head_reg.reg_write;
  assign out_mem_read      = head_reg.mem_read;
  assign out_mem_write     = head_reg.mem_write;
  assign out_branch_taken  = head_reg.branch_taken;

`ifdef ALU_RESULT_STAGE_FWD_EN
  // Loads are excluded: their data does not exist until the memory stage.
  assign fwd_valid = head_valid_reg & head_reg.reg_write & !head_reg.mem_read;
  assign fwd_rd    = head_reg.rd;
  assign fwd_data  = head_reg.s;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, table-driven bench for alu_result_stage plus hand-written stall/flush/reset sequences.
// Forwarding expectations follow ALU_RESULT_STAGE_FWD_EN.

module tb_alu_result_stage;

`ifdef ALU_RESULT_STAGE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] alu_s, store_data, branch_target;
  logic        alu_zero, reg_write, mem_read, mem_write, branch, branch_ne;
  logic [4:0]  rd;
  logic        out_valid, out_ready;
  logic [31:0] out_s, out_store_data, out_branch_target;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch_taken;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_s(alu_s), .alu_zero(alu_zero), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .branch_ne(branch_ne),
    .store_data(store_data), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_store_data(out_store_data), .out_branch_target(out_branch_target),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch_taken(out_branch_taken),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  typedef struct {
    string       name;
    logic [31:0] s;
    logic        zero;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, bne;
    logic [31:0] sd, tgt;
    logic        exp_rw, exp_taken, exp_fwd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; alu_s = 0; alu_zero = 0; rd = 0; reg_write = 0;
    mem_read = 0; mem_write = 0; branch = 0; branch_ne = 0;
    store_data = 0; branch_target = 0;
  endtask

  task automatic push(input logic [31:0] s, input logic [4:0] r, input logic [31:0] sd);
    @(negedge clk);
    in_valid = 1; alu_s = s; rd = r; reg_write = 1; store_data = sd;
    branch_target = s + 32'h1000;
  endtask

  task automatic edge_wait();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{"beq_z1",      32'h100, 1, 5'd0, 0, 0, 0, 1, 0, 32'h0,        32'h400, 0, 1, 0};
    vecs[1] = '{"bne_z1",      32'h101, 1, 5'd0, 0, 0, 0, 1, 1, 32'h0,        32'h404, 0, 0, 0};
    vecs[2] = '{"bne_z0",      32'h102, 0, 5'd0, 0, 0, 0, 1, 1, 32'h0,        32'h408, 0, 1, 0};
    vecs[3] = '{"beq_z0",      32'h103, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0,        32'h40c, 0, 0, 0};
    vecs[4] = '{"nobr_z1",     32'h104, 1, 5'd3, 1, 0, 0, 0, 0, 32'h0,        32'h410, 1, 0, 1};
    vecs[5] = '{"nobr_bne_z0", 32'h105, 0, 5'd4, 1, 0, 0, 0, 1, 32'h0,        32'h414, 1, 0, 1};
    vecs[6] = '{"reg0",        32'hDEADBEEF, 0, 5'd0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0};
    vecs[7] = '{"alu_r5",      32'h1234, 0, 5'd5, 1, 0, 0, 0, 0, 32'h0,       32'h0,   1, 0, 1};
    vecs[8] = '{"load_r5",     32'h1234, 0, 5'd5, 1, 1, 0, 0, 0, 32'h0,       32'h0,   1, 0, 0};
    vecs[9] = '{"store",       32'h200, 0, 5'd0, 0, 0, 1, 0, 0, 32'hCAFEF00D, 32'h0,   0, 0, 0};

    idle_inputs();
    out_ready = 1;
    rst_n = 0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_s", out_s, 0);
    check("reset_fwd_valid", fwd_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Table-driven single-entry transactions, downstream always ready.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1; alu_s = vecs[i].s; alu_zero = vecs[i].zero; rd = vecs[i].rd;
      reg_write = vecs[i].rw; mem_read = vecs[i].mr; mem_write = vecs[i].mw;
      branch = vecs[i].br; branch_ne = vecs[i].bne;
      store_data = vecs[i].sd; branch_target = vecs[i].tgt;
      edge_wait();
      $display("vector %s: out_s=%h taken=%b rw=%b fwd_valid=%b", vecs[i].name, out_s,
               out_branch_taken, out_reg_write, fwd_valid);
      check({vecs[i].name, "_valid"}, out_valid, 1);
      check({vecs[i].name, "_s"}, out_s, vecs[i].s);
      check({vecs[i].name, "_rd"}, out_rd, vecs[i].rd);
      check({vecs[i].name, "_rw"}, out_reg_write, vecs[i].exp_rw);
      check({vecs[i].name, "_mr"}, out_mem_read, vecs[i].mr);
      check({vecs[i].name, "_mw"}, out_mem_write, vecs[i].mw);
      check({vecs[i].name, "_taken"}, out_branch_taken, vecs[i].exp_taken);
      check({vecs[i].name, "_sd"}, out_store_data, vecs[i].sd);
      check({vecs[i].name, "_tgt"}, out_branch_target, vecs[i].tgt);
      check({vecs[i].name, "_fwd_valid"}, fwd_valid, FWD & vecs[i].exp_fwd);
      check({vecs[i].name, "_fwd_rd"}, fwd_rd, FWD ? vecs[i].rd : 5'd0);
      check({vecs[i].name, "_fwd_data"}, fwd_data, FWD ? vecs[i].s : 32'd0);
      check({vecs[i].name, "_in_ready"}, in_ready, 1);
    end
    @(negedge clk); idle_inputs();
    edge_wait();
    check("drain_out_valid", out_valid, 0);

    // Streaming 1..8.
    for (int i = 1; i <= 8; i++) begin
      push(i, 5'd1, 0);
      edge_wait();
      $display("stream entry %0d: out_s=%h in_ready=%b", i, out_s, in_ready);
      check("stream_valid", out_valid, 1);
      check("stream_s", out_s, i);
      check("stream_in_ready", in_ready, 1);
    end
    @(negedge clk); idle_inputs();
    edge_wait();
    check("stream_end_valid", out_valid, 0);

    // Back-pressure: A to head, B to skid, C refused.
    @(negedge clk); out_ready = 0;
    push(32'h11, 5'd2, 32'hA);
    edge_wait();
    check("bp_a_head", out_s, 32'h11);
    check("bp_a_in_ready", in_ready, 1);
    push(32'h22, 5'd3, 32'hB);
    edge_wait();
    check("bp_hold_s", out_s, 32'h11);
    check("bp_hold_sd", out_store_data, 32'hA);
    check("bp_in_ready_low", in_ready, 0);
    push(32'h33, 5'd4, 32'hC);
    edge_wait();
    check("bp_hold2_s", out_s, 32'h11);
    check("bp_in_ready_low2", in_ready, 0);
    @(negedge clk); idle_inputs(); out_ready = 1;
    edge_wait();
    $display("backpressure release: out_s=%h in_ready=%b", out_s, in_ready);
    check("bp_b_valid", out_valid, 1);
    check("bp_b_s", out_s, 32'h22);
    check("bp_b_rd", out_rd, 3);
    check("bp_in_ready_high", in_ready, 1);
    edge_wait();
    check("bp_c_dropped", out_valid, 0);

    // Flush with both entries full and in_valid asserted.
    @(negedge clk); out_ready = 0;
    push(32'h44, 5'd5, 0);
    push(32'h55, 5'd6, 0);
    edge_wait();
    check("fl_full_in_ready", in_ready, 0);
    @(negedge clk); flush = 1; in_valid = 1; alu_s = 32'h66;
    edge_wait();
    $display("flush full: out_valid=%b in_ready=%b", out_valid, in_ready);
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);

    // Flush while in_ready=1: the presented entry is lost.
    @(negedge clk); idle_inputs(); out_ready = 1;
    push(32'h77, 5'd7, 0);
    flush = 1;
    edge_wait();
    check("fl2_out_valid", out_valid, 0);
    @(negedge clk); idle_inputs();
    edge_wait();
    check("fl2_not_captured", out_valid, 0);
    check("fl2_in_ready", in_ready, 1);

    // Asynchronous reset mid-stall.
    @(negedge clk); out_ready = 0;
    push(32'h88, 5'd9, 32'h99);
    branch = 1; alu_zero = 1;
    push(32'hAA, 5'd10, 32'hBB);
    edge_wait();
    check("rst_pre_in_ready", in_ready, 0);
    check("rst_pre_taken", out_branch_taken, 1);
    @(negedge clk); idle_inputs();
    #2 rst_n = 0;
    #1;
    $display("async reset: out_valid=%b out_s=%h in_ready=%b", out_valid, out_s, in_ready);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_s", out_s, 0);
    check("arst_out_rd", out_rd, 0);
    check("arst_out_rw", out_reg_write, 0);
    check("arst_out_sd", out_store_data, 0);
    check("arst_out_tgt", out_branch_target, 0);
    check("arst_out_taken", out_branch_taken, 0);
    check("arst_fwd_data", fwd_data, 0);
    @(negedge clk); rst_n = 1;
    edge_wait();
    check("arst_after_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-to-memory pipeline stage directly downstream of the ALU. Captures the ALU result, zero flag and the instruction's control/destination fields into a 2-entry skid buffer with valid/ready handshakes on both sides. Resolves conditional branches from the zero flag, so the memory stage never needs the raw flag. Optionally exposes the head entry as a bypass source for operand forwarding back into the ALU inputs.

## Interface
- No parameters; widths come from `types::` (`bus_type` = 32 bits).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage can accept.
- `alu_s` in 32: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `rd` in 5: destination register.
- `reg_write`, `mem_read`, `mem_write` in 1 each: control fields.
- `branch` in 1: instruction is a conditional branch.
- `branch_ne` in 1: 1 = bne, 0 = beq.
- `store_data` in 32: rt value for stores.
- `branch_target` in 32: precomputed target.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: downstream accepts.
- `out_s`, `out_store_data`, `out_branch_target` out 32: head entry fields.
- `out_rd` out 5: head entry field.
- `out_reg_write`, `out_mem_read`, `out_mem_write` out 1 each: head entry fields.
- `out_branch_taken` out 1: head entry branch decision.
- `fwd_valid` out 1, `fwd_rd` out 5, `fwd_data` out 32: bypass source.

## Operation
- Storage: head register (drives `out_*`) and skid register, each with a valid bit.
- `in_ready` = !skid_valid. It is a direct function of register state, with no combinational path from `out_ready`.
- An input is accepted when `in_valid & in_ready`. An output transfer occurs when `out_valid & out_ready`.
- Capture rules each cycle, in priority order:
  - Flush clears both valid bits. The accept in the same cycle is discarded and the output transfer is ignored.
  - Head empty, or head transferring, with skid full: skid moves to head. `in_ready` was 0, so nothing is accepted.
  - Head empty, or head transferring, with skid empty: an accepted input goes to head.
  - Head full and not transferring: an accepted input goes to skid.
- Capture-time transforms:
  - `branch_taken` = branch & (alu_zero ^ branch_ne).
  - `reg_write` is forced to 0 when rd == 0.
  - `alu_zero` itself is not stored.
- Order is preserved: skid data always leaves after head data.

## Timing
- Reset values: `out_valid`=0, every `out_*` data field=0, `fwd_*`=0. `in_ready`=1 from reset assertion onward.
- Latency: accepted on edge N, visible on `out_*` after edge N, so 1 cycle.
- Throughput: 1 entry/cycle while `out_ready`=1.
- Back-pressure: the first stalled cycle absorbs one extra entry into skid. `in_ready` falls the cycle after skid fills and rises the cycle after skid drains into head.
- Output fields are held stable while `out_valid & !out_ready`.
- Reset mid-operation: both entries are dropped immediately, asynchronously.
- Flush with `in_valid`=1 and `in_ready`=1: the entry is lost. Upstream treats it as consumed.

## Configuration
- `ALU_RESULT_STAGE_FWD_EN` defined:
  - `fwd_valid` = out_valid & out_reg_write & !out_mem_read.
  - `fwd_rd` = out_rd; `fwd_data` = out_s.
  - Loads are never forwarded.
- Undefined: `fwd_valid`, `fwd_rd` and `fwd_data` are tied to 0, and no forwarding logic is instantiated.

## Test plan
- Streaming: 8 entries `alu_s`=1..8 with `out_ready`=1 -> `out_s` = 1..8 on consecutive cycles, one cycle after each accept, `in_ready` stays 1.
- Back-pressure:
  - Stimulus: `out_ready`=0 with entries A=0x11, B=0x22 presented back-to-back.
  - Required: A is held in head and B goes to skid; `in_ready`=0 from the next cycle.
  - Release: raise `out_ready` -> A then B emerge, and `in_ready`=1 the cycle after B reaches head.
- Branch decision:
  - beq with `alu_zero`=1 -> `out_branch_taken`=1.
  - bne with `alu_zero`=1 -> 0.
  - bne with `alu_zero`=0 -> 1.
  - `branch`=0 -> 0 regardless of `alu_zero`.
- Register 0: `rd`=0, `reg_write`=1, `alu_s`=0xDEADBEEF -> `out_reg_write`=0, `fwd_valid`=0.
- Flush: both entries full, then assert `flush` together with `in_valid` -> `out_valid`=0 and `in_ready`=1 next cycle, and the input is not captured. Async reset: `rst_n` low mid-stall -> all outputs 0 immediately.
- Forwarding (macro defined): head holds an ALU op with rd=5, 0x1234 -> `fwd_valid`=1, `fwd_rd`=5, `fwd_data`=0x1234. The same fields on a load -> `fwd_valid`=0. Macro undefined -> `fwd_*` always 0.
